// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and constants for the unified memory port
//               arbiter (state encoding, instruction width, starve default).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Instruction word width carried on the fetch side
    localparam int INSN_W = 32;

    // Default number of back-to-back MEM grants tolerated while IF waits
    localparam int STARVE_MAX_DEFAULT = 4;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_IF_BUSY  = 2'd1,
        ST_MEM_BUSY = 2'd2,
        ST_IF_DROP  = 2'd3
    } arb_state_e;

    // Counter width able to hold 0..max inclusive
    function automatic int starve_cnt_width(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Requester (IF / MEM stage) and memory-bus signal bundle for
//               the unified memory port arbiter. The slave modport is the
//               arbiter's view; master is the surrounding pipeline + bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    import mem_port_arbiter_pkg::*;

    // Instruction fetch side
    logic                   if_req;
    logic [ADDR_W-1:0]      if_addr;
    logic                   flush;
    logic [INSN_W-1:0]      if_rdata;
    logic                   if_stall;

    // Data access side
    logic                   mem_re;
    logic                   mem_we;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W/8-1:0]    mem_wmask;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mem_stall;

    // Shared memory bus
    logic                   bus_req;
    logic                   bus_we;
    logic [ADDR_W-1:0]      bus_addr;
    logic [DATA_W-1:0]      bus_wdata;
    logic [DATA_W/8-1:0]    bus_wmask;
    logic [DATA_W-1:0]      bus_rdata;
    logic                   bus_ack;

    modport slave (
        input  if_req, if_addr, flush,
        output if_rdata, if_stall,
        input  mem_re, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_rdata, mem_stall,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
        input  bus_rdata, bus_ack
    );

    modport master (
        output if_req, if_addr, flush,
        input  if_rdata, if_stall,
        output mem_re, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_rdata, mem_stall,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
        output bus_rdata, bus_ack
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_starve_counter
// Description : Saturating count of consecutive MEM grants taken while a
//               fetch is waiting. Clear has priority over increment.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic inc_i,
    input  wire logic clr_i,
    output logic      at_max_o
);

    localparam int              C_CNT_W = starve_cnt_width(STARVE_MAX);
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(STARVE_MAX);

    logic [C_CNT_W-1:0] cnt_q;
    logic [C_CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up until saturated
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != C_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max_o = (cnt_q == C_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and the MEM
//               stage. MEM has fixed priority, a starvation guard forces an
//               IF grant after STARVE_MAX consecutive MEM grants, and a
//               fetch in flight during a flush is completed and discarded.
//               One outstanding bus transaction, req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  wire logic            clk,
    input  wire logic            rst,
    mem_port_arbiter_if.slave    port_io
);

    arb_state_e             state_q, state_d;
    logic                   word_sel_q, word_sel_d;
    logic                   bus_req_q, bus_req_d;
    logic                   bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]      bus_wdata_q, bus_wdata_d;
    logic [DATA_W/8-1:0]    bus_wmask_q, bus_wmask_d;

    logic                   w_mem_any;
    logic                   w_if_grant;
    logic                   w_mem_grant;
    logic                   w_starve_at_max;
    logic                   w_if_done;
    logic                   w_mem_done;
    logic                   w_unused_addr_lsb;

    assign w_mem_any = port_io.mem_re | port_io.mem_we;

    // Word-aligned fetch addresses: the low two bits carry no information
    assign w_unused_addr_lsb = ^port_io.if_addr[1:0];

    // Starvation guard: counts MEM wins while IF is waiting
    mem_port_arbiter_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk      (clk),
        .rst      (rst),
        .inc_i    (w_mem_grant & port_io.if_req),
        .clr_i    (w_if_grant | ~port_io.if_req),
        .at_max_o (w_starve_at_max)
    );

    // Arbitration, next state and bus register loading
    always_comb begin
        state_d     = state_q;
        word_sel_d  = word_sel_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_wmask_d = bus_wmask_q;
        w_if_grant  = 1'b0;
        w_mem_grant = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A flushed fetch is never granted, even when forced
                if (w_mem_any) begin
                    if (w_starve_at_max && port_io.if_req && !port_io.flush) begin
                        w_if_grant = 1'b1;
                    end else begin
                        w_mem_grant = 1'b1;
                    end
                end else if (port_io.if_req && !port_io.flush) begin
                    w_if_grant = 1'b1;
                end

                if (w_if_grant) begin
                    state_d     = ST_IF_BUSY;
                    word_sel_d  = port_io.if_addr[2];
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {port_io.if_addr[ADDR_W-1:3], 3'b000};
                    bus_wdata_d = '0;
                    bus_wmask_d = '0;
                end else if (w_mem_grant) begin
                    state_d     = ST_MEM_BUSY;
                    bus_req_d   = 1'b1;
                    bus_we_d    = port_io.mem_we;
                    bus_addr_d  = port_io.mem_addr;
                    bus_wdata_d = port_io.mem_we ? port_io.mem_wdata : '0;
                    bus_wmask_d = port_io.mem_we ? port_io.mem_wmask : '0;
                end
            end

            ST_IF_BUSY: begin
                // The bus request cannot be withdrawn; a flush only marks
                // the returning data as stale
                if (port_io.bus_ack) begin
                    state_d = ST_IDLE;
                end else if (port_io.flush) begin
                    state_d = ST_IF_DROP;
                end
            end

            ST_IF_DROP: begin
                if (port_io.bus_ack) begin
                    state_d = ST_IDLE;
                end
            end

            ST_MEM_BUSY: begin
                if (port_io.bus_ack) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every transaction ends through IDLE with the bus quiet
        if ((state_q != ST_IDLE) && port_io.bus_ack) begin
            bus_req_d   = 1'b0;
            bus_we_d    = 1'b0;
            bus_addr_d  = '0;
            bus_wdata_d = '0;
            bus_wmask_d = '0;
        end
    end

    // State and bus registers; reset abandons any transfer in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_sel_q  <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
        end else begin
            state_q     <= state_d;
            word_sel_q  <= word_sel_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_wmask_q <= bus_wmask_d;
        end
    end

    // Completion strobes: a fetch acked under flush is not delivered
    assign w_if_done  = (state_q == ST_IF_BUSY) & port_io.bus_ack & ~port_io.flush;
    assign w_mem_done = (state_q == ST_MEM_BUSY) & port_io.bus_ack;

    assign port_io.if_stall  = port_io.if_req & ~w_if_done;
    assign port_io.mem_stall = w_mem_any & ~w_mem_done;

    assign port_io.if_rdata  = !w_if_done ? '0 :
                               word_sel_q ? port_io.bus_rdata[2*INSN_W-1:INSN_W]
                                          : port_io.bus_rdata[INSN_W-1:0];
    assign port_io.mem_rdata = w_mem_done ? port_io.bus_rdata : '0;

    assign port_io.bus_req   = bus_req_q;
    assign port_io.bus_we    = bus_we_q;
    assign port_io.bus_addr  = bus_addr_q;
    assign port_io.bus_wdata = bus_wdata_q;
    assign port_io.bus_wmask = bus_wmask_q;

endmodule
`default_nettype wire
